// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory readback path.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    REQ,
    WAIT_RV,
    SEND,
    CSUM,
    FIN
  } rb_state_e;

  localparam logic [7:0] HDR_BYTE_DEF    = 8'hA5;
  localparam logic [7:0] ERR_BYTE_DEF    = 8'hEE;
  localparam int         UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready byte handshake; TX idles high.
module uart_tx_byte
  import boot_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       TX
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(UART_FRAME_BITS);

  logic             active_q;
  logic             tx_q;
  logic [8:0]       shift_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic             last_cycle;

  assign last_cycle = (div_q == DIV_W'(CLK_DIV - 1)) &&
                      (bit_q == BIT_W'(UART_FRAME_BITS - 1));

  // Ready also rises in the final stop-bit cycle, so a queued byte starts
  // its start bit immediately after the stop bit with no idle gap.
  assign byte_ready = !active_q || last_cycle;
  assign TX         = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
    end else if (byte_valid && byte_ready) begin
      active_q <= 1'b1;
      tx_q     <= 1'b0;
      shift_q  <= {1'b1, byte_data};
      div_q    <= '0;
      bit_q    <= '0;
    end else if (active_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_q <= '0;
        if (bit_q == BIT_W'(UART_FRAME_BITS - 1)) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + BIT_W'(1);
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/boot_readback.sv
// Bus-master readback of instruction memory, streamed as a framed,
// checksummed byte dump over UART TX.
module boot_readback
  import boot_pkg::*;
#(
  parameter int         CLK_DIV  = 16,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF,
  parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             req,
  input  logic             gnt,
  input  logic             rvalid,
  input  logic [31:0]      rdata,
  input  logic             err,
  output logic [31:0]      addr,
  output logic             we,
  output logic [3:0]       be,
  output logic             TX,
  output logic             busy,
  output logic             done,
  output logic             error
);

  rb_state_e        state_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] remain_q;
  logic [31:0]      word_q;
  logic [1:0]       byte_idx_q;
  logic [7:0]       csum_q;
  logic             error_q;
  logic             busy_q;
  logic             done_q;
  logic             req_q;

  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;

  assign req   = req_q;
  assign addr  = addr_q;
  assign we    = 1'b0;
  assign be    = 4'hF;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    case (state_q)
      HDR: begin
        byte_valid = 1'b1;
        byte_data  = HDR_BYTE;
      end
      SEND: begin
        byte_valid = 1'b1;
        case (byte_idx_q)
          2'd0:    byte_data = word_q[7:0];
          2'd1:    byte_data = word_q[15:8];
          2'd2:    byte_data = word_q[23:16];
          default: byte_data = word_q[31:24];
        endcase
      end
      CSUM: begin
        byte_valid = 1'b1;
        byte_data  = error_q ? ERR_BYTE : csum_q;
      end
      default: ;
    endcase
  end

  // In FIN the serializer's ready marks the last stop-bit cycle, so done
  // lands in the first cycle after the line has fully returned to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      csum_q     <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          addr_q   <= base_addr & 32'hFFFF_FFFC;
          remain_q <= word_cnt;
          csum_q   <= '0;
          error_q  <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= HDR;
        end
        HDR: if (byte_ready) begin
          if (remain_q != '0) begin
            req_q   <= 1'b1;
            state_q <= REQ;
          end else begin
            state_q <= CSUM;
          end
        end
        REQ: if (gnt) begin
          req_q   <= 1'b0;
          state_q <= WAIT_RV;
        end
        WAIT_RV: if (rvalid) begin
          if (err) begin
            error_q <= 1'b1;
            state_q <= CSUM;
          end else begin
            word_q     <= rdata;
            addr_q     <= addr_q + 32'd4;
            remain_q   <= remain_q - CNT_W'(1);
            byte_idx_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: if (byte_ready) begin
          csum_q <= csum_q + byte_data;
          if (byte_idx_q == 2'd3) begin
            byte_idx_q <= '0;
            if (remain_q != '0) begin
              req_q   <= 1'b1;
              state_q <= REQ;
            end else begin
              state_q <= CSUM;
            end
          end else begin
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        CSUM: if (byte_ready) state_q <= FIN;
        FIN: if (byte_ready) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .TX        (TX)
  );

endmodule

// File: tb/tb_boot_readback.sv
// Scoreboard bench for boot_readback: a bus responder and a UART receiver
// pop expected addresses and bytes pushed by the directed stimulus.
module tb_boot_readback;

  localparam int CLK_DIV = 16;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_cnt;
  logic             req;
  logic             gnt;
  logic             rvalid;
  logic [31:0]      rdata;
  logic             err;
  logic [31:0]      addr;
  logic             we;
  logic [3:0]       be;
  logic             TX;
  logic             busy;
  logic             done;
  logic             error;

  int checks   = 0;
  int failures = 0;
  int gntDelay = 0;
  int rvDelay  = 0;
  int reqCount = 0;
  int doneCount = 0;
  bit rxEnable = 1'b1;

  logic [7:0]  expByteQ[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] rspDataQ[$];
  logic        rspErrQ[$];

  always #5 clk = ~clk;

  boot_readback #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .word_cnt (word_cnt),
    .req      (req),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .err      (err),
    .addr     (addr),
    .we       (we),
    .be       (be),
    .TX       (TX),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    base_addr = base;
    word_cnt  = cnt;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
    checkOutput("busy_at_done", 32'(busy), 32'd0);
    checkOutput("bytes_drained", 32'(expByteQ.size()), 32'd0);
    checkOutput("addrs_drained", 32'(expAddrQ.size()), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic pushBytes(input logic [7:0] b[]);
    foreach (b[i]) expByteQ.push_back(b[i]);
  endtask

  always @(negedge clk) if (done === 1'b1) doneCount++;

  // Bus responder: grants after gntDelay, answers after rvDelay.
  initial begin : busModel
    logic [31:0] reqAddr;
    bit          stable;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = '0;
    err    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && req === 1'b1) begin
        reqCount++;
        reqAddr = addr;
        stable  = 1'b1;
        if (expAddrQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_req actual=%h required=no_request", reqAddr);
        end else begin
          checkOutput("req_addr", reqAddr, expAddrQ.pop_front());
        end
        for (int i = 0; i < gntDelay; i++) begin
          @(negedge clk);
          if (req !== 1'b1 || addr !== reqAddr) stable = 1'b0;
        end
        if (gntDelay > 0) checkOutput("req_stable", 32'(stable), 32'd1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        checkOutput("req_dropped", 32'(req), 32'd0);
        for (int i = 0; i < rvDelay; i++) @(negedge clk);
        if (rspDataQ.size() > 0) begin
          rdata = rspDataQ.pop_front();
          err   = rspErrQ.pop_front();
        end else begin
          rdata = 32'h0;
          err   = 1'b1;
        end
        rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        err    = 1'b0;
        rdata  = '0;
      end
    end
  end

  // UART receiver sampling mid-bit; compares every byte to the scoreboard.
  initial begin : uartMonitor
    logic [7:0] rxByte;
    logic       stopBit;
    rxByte = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          rxByte[i] = TX;
        end
        repeat (CLK_DIV) @(negedge clk);
        stopBit = TX;
        if (rxEnable) begin
          checkOutput("stop_bit", 32'(stopBit), 32'd1);
          if (expByteQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_byte actual=%h required=no_byte", rxByte);
          end else begin
            checkOutput("tx_byte", 32'(rxByte), 32'(expByteQ.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int cycles;
    int doneBefore;
    int reqBefore;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    word_cnt  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(TX), 32'd1);
    checkOutput("reset_req", 32'(req), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_addr", addr, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] one word dump");
    gntDelay = 0;
    rvDelay  = 0;
    expAddrQ.push_back(32'h0000_0100);
    rspDataQ.push_back(32'h1234_5678); rspErrQ.push_back(1'b0);
    pushBytes('{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14});
    applyStimulus(32'h0000_0100, 16'd1);
    checkOutput("latency_tx_high", 32'(TX), 32'd1);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("latency_tx_start", 32'(TX), 32'd0);
    waitDone(200 * CLK_DIV, cycles);
    checkOutput("one_word_cycles", 32'(cycles), 32'(60 * CLK_DIV));

    $display("[TB] stalled bus, two words");
    gntDelay = 5;
    rvDelay  = 3;
    expAddrQ.push_back(32'h0000_2000);
    expAddrQ.push_back(32'h0000_2004);
    rspDataQ.push_back(32'hDEAD_BEEF); rspErrQ.push_back(1'b0);
    rspDataQ.push_back(32'h0BAD_F00D); rspErrQ.push_back(1'b0);
    pushBytes('{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'hED});
    applyStimulus(32'h0000_2003, 16'd2);
    waitDone(300 * CLK_DIV, cycles);

    $display("[TB] empty dump");
    gntDelay   = 0;
    rvDelay    = 0;
    doneBefore = doneCount;
    reqBefore  = reqCount;
    pushBytes('{8'hA5, 8'h00});
    applyStimulus(32'h0000_0040, 16'd0);
    waitDone(100 * CLK_DIV, cycles);
    repeat (5) @(negedge clk);
    checkOutput("empty_done_count", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("empty_req_count", 32'(reqCount - reqBefore), 32'd0);

    $display("[TB] bus error on second word");
    reqBefore = reqCount;
    expAddrQ.push_back(32'h0000_0300);
    expAddrQ.push_back(32'h0000_0304);
    rspDataQ.push_back(32'hCAFE_BABE); rspErrQ.push_back(1'b0);
    rspDataQ.push_back(32'h0000_0000); rspErrQ.push_back(1'b1);
    pushBytes('{8'hA5, 8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'hEE});
    applyStimulus(32'h0000_0300, 16'd3);
    waitDone(200 * CLK_DIV, cycles);
    checkOutput("error_sticky", 32'(error), 32'd1);
    checkOutput("error_req_count", 32'(reqCount - reqBefore), 32'd2);

    $display("[TB] address wrap with ignored start");
    expAddrQ.push_back(32'hFFFF_FFFC);
    expAddrQ.push_back(32'h0000_0000);
    rspDataQ.push_back(32'h0102_0304); rspErrQ.push_back(1'b0);
    rspDataQ.push_back(32'hA0B0_C0D0); rspErrQ.push_back(1'b0);
    pushBytes('{8'hA5, 8'h04, 8'h03, 8'h02, 8'h01, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'hEA});
    applyStimulus(32'hFFFF_FFFC, 16'd2);
    checkOutput("error_cleared", 32'(error), 32'd0);
    repeat (100) @(negedge clk);
    applyStimulus(32'h0000_0500, 16'd5);
    checkOutput("busy_ignores_start", 32'(busy), 32'd1);
    waitDone(300 * CLK_DIV, cycles);

    $display("[TB] reset mid-frame");
    rxEnable = 1'b0;
    expAddrQ.push_back(32'h0000_0400);
    rspDataQ.push_back(32'h5555_AAAA); rspErrQ.push_back(1'b0);
    applyStimulus(32'h0000_0400, 16'd1);
    @(negedge clk);
    checkOutput("midframe_start_bit", 32'(TX), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe_reset_tx", 32'(TX), 32'd1);
    checkOutput("midframe_reset_busy", 32'(busy), 32'd0);
    checkOutput("midframe_reset_req", 32'(req), 32'd0);
    checkOutput("midframe_reset_error", 32'(error), 32'd0);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
